// File: rtl/dequant_tile_sched.sv
// Scale-fetch scheduler for one dequant job: one credit-limited scale-matrix request per output block, result-row index check, done/err.
// Latency: start->deq_clear 1 cycle, ->first request 2 cycles, last result->done 2 cycles; request held while !scl_req_ready, paused at zero credit.
module dequant_tile_sched #(
    parameter int LANES_NUM   = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int CNT_W       = 10,
    parameter int ADDR_W      = 32,
    parameter int ADDR_STRIDE = 256,
    parameter int ROWS_MAX    = 1024,
    parameter int ROW_W       = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  cfg_blk_rows,
    input  logic [CNT_W-1:0]  cfg_blk_cols,
    input  logic [ADDR_W-1:0] cfg_scl_base,
    output logic              scl_req_valid,
    input  logic              scl_req_ready,
    output logic [ADDR_W-1:0] scl_req_addr,
    input  logic              scale_pop,
    input  logic              res_fire,
    input  logic [ROW_W-1:0]  res_row_idx,
    output logic              deq_clear,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int BLK_W = 2 * CNT_W;
    localparam int TRW   = BLK_W + $clog2(LANES_NUM) + 1;
    localparam int CRD_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {S_IDLE, S_CLR, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [BLK_W-1:0]   total_blk_q, total_blk_d;
    logic [BLK_W-1:0]   issued_q, issued_d;
    logic [TRW-1:0]     total_rows_q, total_rows_d;
    logic [TRW-1:0]     res_cnt_q, res_cnt_d;
    logic [ROW_W-1:0]   row_exp_q, row_exp_d;
    logic [CRD_W-1:0]   credit_q, credit_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               err_q, err_d;
    logic               zdone_q, zdone_d;
    logic               aclr_q, aclr_d;

    logic               active;
    logic               req_vld;
    logic               req_fire;
    logic               cfg_zero;
    logic [BLK_W-1:0]   blk_prod;

    always_comb begin
        active   = (state_q == S_RUN) || (state_q == S_DRAIN);
        // Abort drops the request in its own cycle so no fetch slips out after cancel.
        req_vld  = (state_q == S_RUN) && (issued_q < total_blk_q) &&
                   (credit_q != '0) && !abort;
        req_fire = req_vld && scl_req_ready;
        cfg_zero = (cfg_blk_rows == '0) || (cfg_blk_cols == '0);
        blk_prod = BLK_W'(cfg_blk_rows) * BLK_W'(cfg_blk_cols);

        state_d      = state_q;
        total_blk_d  = total_blk_q;
        total_rows_d = total_rows_q;
        issued_d     = issued_q;
        res_cnt_d    = res_cnt_q;
        row_exp_d    = row_exp_q;
        credit_d     = credit_q;
        addr_d       = addr_q;
        err_d        = err_q;
        zdone_d      = 1'b0;
        aclr_d       = 1'b0;

        case ({req_fire, scale_pop})
            2'b10: credit_d = credit_q - CRD_W'(1);
            2'b01: begin
                if (credit_q == CRD_W'(FIFO_DEPTH)) begin
                    err_d = 1'b1;
                end else begin
                    credit_d = credit_q + CRD_W'(1);
                end
            end
            default: ;
        endcase

        if (req_fire) begin
            addr_d   = addr_q + ADDR_W'(ADDR_STRIDE);
            issued_d = issued_q + BLK_W'(1);
        end

        if (active && res_fire) begin
            if (res_row_idx != row_exp_q) begin
                err_d = 1'b1;
            end
            res_cnt_d = res_cnt_q + TRW'(1);
            row_exp_d = (row_exp_q == ROW_W'(ROWS_MAX - 1)) ? '0 : row_exp_q + ROW_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cfg_zero) begin
                        zdone_d = 1'b1;
                    end else begin
                        total_blk_d  = blk_prod;
                        total_rows_d = TRW'(blk_prod) * TRW'(LANES_NUM);
                        addr_d       = cfg_scl_base;
                        err_d        = 1'b0;
                        state_d      = S_CLR;
                    end
                end
            end
            S_CLR: begin
                issued_d  = '0;
                res_cnt_d = '0;
                row_exp_d = '0;
                credit_d  = CRD_W'(FIFO_DEPTH);
                state_d   = S_RUN;
            end
            S_RUN: begin
                if (abort) begin
                    aclr_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (req_fire && (issued_q + BLK_W'(1) == total_blk_q)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    aclr_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (res_cnt_q == total_rows_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            total_blk_q  <= '0;
            total_rows_q <= '0;
            issued_q     <= '0;
            res_cnt_q    <= '0;
            row_exp_q    <= '0;
            credit_q     <= CRD_W'(FIFO_DEPTH);
            addr_q       <= '0;
            err_q        <= 1'b0;
            zdone_q      <= 1'b0;
            aclr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            total_blk_q  <= total_blk_d;
            total_rows_q <= total_rows_d;
            issued_q     <= issued_d;
            res_cnt_q    <= res_cnt_d;
            row_exp_q    <= row_exp_d;
            credit_q     <= credit_d;
            addr_q       <= addr_d;
            err_q        <= err_d;
            zdone_q      <= zdone_d;
            aclr_q       <= aclr_d;
        end
    end

    assign scl_req_valid = req_vld;
    assign scl_req_addr  = addr_q;
    assign deq_clear     = (state_q == S_CLR) || aclr_q;
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE) || zdone_q;
    assign err           = err_q;

endmodule

// File: tb/tb_dequant_tile_sched.sv
// Bench for dequant_tile_sched: table of jobs plus random jobs against an arithmetic job model,
// with hand sequences for reset, zero-size start, credit stall, abort and mid-job reset.
module tb_dequant_tile_sched;
    localparam int LANES = 4;
    localparam int DEPTH = 4;
    localparam int RMAX  = 1024;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [9:0]  cfg_blk_rows;
    logic [9:0]  cfg_blk_cols;
    logic [31:0] cfg_scl_base;
    logic        scl_req_valid;
    logic        scl_req_ready;
    logic [31:0] scl_req_addr;
    logic        scale_pop;
    logic        res_fire;
    logic [9:0]  res_row_idx;
    logic        deq_clear;
    logic        busy;
    logic        done;
    logic        err;

    int n_chk = 0;
    int n_err = 0;

    dequant_tile_sched dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .cfg_blk_rows  (cfg_blk_rows),
        .cfg_blk_cols  (cfg_blk_cols),
        .cfg_scl_base  (cfg_scl_base),
        .scl_req_valid (scl_req_valid),
        .scl_req_ready (scl_req_ready),
        .scl_req_addr  (scl_req_addr),
        .scale_pop     (scale_pop),
        .res_fire      (res_fire),
        .res_row_idx   (res_row_idx),
        .deq_clear     (deq_clear),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          rows;
        int          cols;
        logic [31:0] base;
        int          stall;
        int          corrupt_at;
        bit          spurious;
        bit          rnd;
        int          exp_reqs;
        logic [31:0] exp_last;
        bit          exp_err;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start         = 1'b0;
        abort         = 1'b0;
        scl_req_ready = 1'b0;
        scale_pop     = 1'b0;
        res_fire      = 1'b0;
        res_row_idx   = '0;
    endtask

    // Environment: a fired request becomes a FIFO matrix next cycle; each matrix yields LANES rows,
    // the last of which pops it. Row index is the global result count mod RMAX.
    task automatic run_job(input vec_t v, input string nm);
        int          occ = 0;
        int          head = 0;
        int          sent = 0;
        int          n_fire = 0;
        int          done_cnt = 0;
        int          done_cyc = -1;
        int          last_res = -1;
        int          bad_cyc = -1;
        int          clr_extra = 0;
        int          limit = v.exp_reqs * 16 + 200;
        logic [31:0] exp_addr = v.base;
        logic [31:0] last_addr = 32'hDEAD_BEEF;
        logic [31:0] rb;
        logic [9:0]  ri;
        bit          fire;
        bit          fin = 1'b0;
        for (int cyc = 0; cyc < limit && !fin; cyc++) begin
            start = (cyc == 0);
            abort = 1'b0;
            if (cyc == 0) begin
                cfg_blk_rows = 10'(v.rows);
                cfg_blk_cols = 10'(v.cols);
                cfg_scl_base = v.base;
            end else if (v.spurious && done_cnt == 0 && $urandom_range(0, 5) == 0) begin
                start        = 1'b1;
                cfg_blk_rows = 10'($urandom_range(0, 9));
                cfg_blk_cols = 10'($urandom_range(1, 9));
                rb           = $urandom;
                cfg_scl_base = rb;
            end
            if (cyc < 2 + v.stall) scl_req_ready = 1'b0;
            else scl_req_ready = v.rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            res_fire = (occ > 0) && (!v.rnd || $urandom_range(0, 3) != 0);
            ri = 10'(sent % RMAX);
            if (sent == v.corrupt_at) ri = ri + 10'd1;
            res_row_idx = ri;
            scale_pop   = res_fire && (head == LANES - 1);
            #1;
            if (cyc == 1) begin
                chk1({nm, " clr_lat"}, deq_clear, 1'b1);
                chk1({nm, " busy_lat"}, busy, 1'b1);
            end
            if (cyc == 2) chk1({nm, " req_lat"}, scl_req_valid, 1'b1);
            if (cyc >= 2 && deq_clear) clr_extra++;
            if (cyc >= 2 && cyc < 2 + v.stall) begin
                chk1({nm, " stall_vld"}, scl_req_valid, 1'b1);
                chk({nm, " stall_addr"}, scl_req_addr, v.base);
            end
            if (bad_cyc >= 0 && cyc == bad_cyc + 1) chk1({nm, " err_set"}, err, 1'b1);
            if (res_fire && sent == v.corrupt_at) begin
                chk1({nm, " err_pre"}, err, 1'b0);
                bad_cyc = cyc;
            end
            fire = scl_req_valid && scl_req_ready;
            if (fire) begin
                chk({nm, " req_addr"}, scl_req_addr, exp_addr);
                chk1({nm, " credit"}, occ < DEPTH, 1'b1);
                last_addr = scl_req_addr;
                exp_addr  = exp_addr + 32'd256;
                n_fire++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (res_fire) begin
                sent++;
                head = (head + 1) % LANES;
                last_res = cyc;
            end
            if (scale_pop) occ--;
            if (fire) occ++;
            if (done_cyc >= 0 && cyc >= done_cyc + 2) fin = 1'b1;
            nxt();
        end
        idle_inputs();
        #1;
        chk1({nm, " timeout"}, fin, 1'b1);
        chk({nm, " n_req"}, n_fire, v.exp_reqs);
        chk({nm, " last_addr"}, last_addr, v.exp_last);
        chk({nm, " n_rows"}, sent, v.exp_reqs * LANES);
        chk({nm, " done_cnt"}, done_cnt, 1);
        chk({nm, " done_lat"}, done_cyc, last_res + 2);
        chk1({nm, " err_end"}, err, v.exp_err);
        chk({nm, " clr_extra"}, clr_extra, 0);
        chk1({nm, " busy_end"}, busy, 1'b0);
        nxt();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[6];
        vec_t rv;
        int   fires;
        int   done_seen;
        logic [31:0] b;

        tbl[0] = '{2, 3, 32'h0000_1000, 0, -1, 1'b0, 1'b0, 6, 32'h0000_1500, 1'b0};
        tbl[1] = '{1, 1, 32'h0000_0000, 0, -1, 1'b0, 1'b1, 1, 32'h0000_0000, 1'b0};
        tbl[2] = '{1, 2, 32'hFFFF_FF00, 1, -1, 1'b1, 1'b1, 2, 32'h0000_0000, 1'b0};
        tbl[3] = '{3, 2, 32'h0000_3000, 5, 2, 1'b0, 1'b1, 6, 32'h0000_3500, 1'b1};
        tbl[4] = '{4, 5, 32'h0000_2000, 0, -1, 1'b1, 1'b1, 20, 32'h0000_3300, 1'b0};
        tbl[5] = '{16, 17, 32'h4000_0000, 0, -1, 1'b0, 1'b1, 272, 32'h4001_0F00, 1'b0};

        rst = 1'b1;
        cfg_blk_rows = '0;
        cfg_blk_cols = '0;
        cfg_scl_base = '0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk1("rst_vld", scl_req_valid, 1'b0);
        chk("rst_addr", scl_req_addr, 32'h0);
        chk1("rst_clr", deq_clear, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_err", err, 1'b0);
        nxt();

        // Zero-sized jobs: immediate done, nothing else.
        start = 1'b1; cfg_blk_rows = 10'd0; cfg_blk_cols = 10'd3; cfg_scl_base = 32'h500;
        nxt();
        start = 1'b0;
        #1;
        chk1("zero_done", done, 1'b1);
        chk1("zero_busy", busy, 1'b0);
        chk1("zero_clr", deq_clear, 1'b0);
        chk1("zero_vld", scl_req_valid, 1'b0);
        nxt();
        chk1("zero_done_end", done, 1'b0);
        start = 1'b1; cfg_blk_rows = 10'd2; cfg_blk_cols = 10'd0;
        nxt();
        start = 1'b0;
        #1;
        chk1("zero_col_done", done, 1'b1);
        chk1("zero_col_busy", busy, 1'b0);
        nxt();

        // Credit exhaustion with no pops, single pop resumes, then reset mid-job.
        cfg_blk_rows = 10'd4; cfg_blk_cols = 10'd4; cfg_scl_base = 32'h8000;
        scl_req_ready = 1'b1;
        fires = 0;
        done_seen = 0;
        for (int i = 0; i < 14; i++) begin
            start = (i == 0);
            #1;
            if (scl_req_valid && scl_req_ready) fires++;
            if (done) done_seen++;
            nxt();
        end
        #1;
        chk("crd_fires", fires, DEPTH);
        chk1("crd_stall", scl_req_valid, 1'b0);
        scale_pop = 1'b1;
        nxt();
        scale_pop = 1'b0;
        #1;
        chk1("crd_resume", scl_req_valid, 1'b1);
        chk("crd_addr", scl_req_addr, 32'h8400);
        nxt();
        chk1("crd_refill", scl_req_valid, 1'b0);
        chk1("crd_busy", busy, 1'b1);
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        #1;
        chk1("mrst_busy", busy, 1'b0);
        chk1("mrst_vld", scl_req_valid, 1'b0);
        chk("mrst_addr", scl_req_addr, 32'h0);
        chk1("mrst_clr", deq_clear, 1'b0);
        nxt();
        chk1("mrst_clr2", deq_clear, 1'b0);
        chk("crd_no_done", done_seen, 0);

        // Abort after two requests.
        cfg_blk_rows = 10'd2; cfg_blk_cols = 10'd2; cfg_scl_base = 32'h9000;
        scl_req_ready = 1'b1;
        fires = 0;
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            start = (i == 0);
            #1;
            if (scl_req_valid && scl_req_ready) fires++;
            nxt();
        end
        chk("ab_fires", fires, 2);
        abort = 1'b1;
        #1;
        chk1("ab_busy_pre", busy, 1'b1);
        nxt();
        abort = 1'b0;
        scl_req_ready = 1'b0;
        #1;
        chk1("ab_clr", deq_clear, 1'b1);
        chk1("ab_busy", busy, 1'b0);
        chk1("ab_vld", scl_req_valid, 1'b0);
        if (done) done_seen++;
        for (int i = 0; i < 4; i++) begin
            nxt();
            if (done) done_seen++;
            if (i == 0) chk1("ab_clr_end", deq_clear, 1'b0);
        end
        chk("ab_no_done", done_seen, 0);

        for (int i = 0; i < 6; i++) run_job(tbl[i], $sformatf("tbl%0d", i));

        for (int j = 0; j < 4; j++) begin
            rv.rows       = $urandom_range(1, 5);
            rv.cols       = $urandom_range(1, 5);
            b             = $urandom;
            rv.base       = b & 32'hFFFF_FF00;
            rv.stall      = $urandom_range(0, 3);
            rv.corrupt_at = ($urandom_range(0, 2) == 0) ?
                            $urandom_range(0, rv.rows * rv.cols * LANES - 1) : -1;
            rv.spurious   = 1'b1;
            rv.rnd        = 1'b1;
            rv.exp_reqs   = rv.rows * rv.cols;
            rv.exp_last   = rv.base + 32'((rv.exp_reqs - 1) * 256);
            rv.exp_err    = (rv.corrupt_at >= 0);
            run_job(rv, $sformatf("rnd%0d", j));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
